// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN             : address / instruction width
//   INST_NOP         : canonical RV32I nop (addi x0, x0, 0), used for bubbles and flushes
//   RESET_PC_DEFAULT : default fetch address after reset
//   if_state_e       : fetch FSM state encoding (2-bit)
package if_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,  // ready to issue a request at fetch_pc
    StWait = 2'd1,  // request in flight, response wanted
    StDrop = 2'd2,  // request in flight, response stale (redirected)
    StFull = 2'd3   // response captured in skid buffer, waiting for commit
  } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: rst > flush > hold (write_i=0) > load > bubble.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   flush_i              : squash the held instruction (wrong path)
//   write_i              : 0 holds the register
//   load_i               : capture pc_i / inst_i as a valid instruction
//   pc_i, inst_i         : incoming PC and instruction
//   pc_o, pc4_o, inst_o  : registered PC, PC+4 (link value), instruction
//   valid_o              : register holds a real instruction
module if_id_reg
  import if_fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            write_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] pc4_d, pc4_q;
  logic [XLEN-1:0] inst_d, inst_q;
  logic            valid_d, valid_q;

  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      inst_d  = INST_NOP;
      valid_d = 1'b0;
    end else if (write_i) begin
      if (load_i) begin
        pc_d    = pc_i;
        pc4_d   = pc_i + XLEN'(4);  // wraps modulo 2^XLEN
        inst_d  = inst_i;
        valid_d = 1'b1;
      end else begin
        // Bubble: PC fields keep their last value, only the payload is squashed.
        inst_d  = INST_NOP;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      pc4_q   <= XLEN'(4);
      inst_q  <= INST_NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding reads to
// instruction memory, buffers a response that arrives during a stall, drops stale
// responses after a redirect and feeds the IF/ID register.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pcwrite, ifidwrite       : hazard-unit stall controls (both must be 1 to commit)
//   redirect, target_pc      : EX-stage redirect; target_pc[1:0] ignored
//   imem_req, imem_addr      : one-cycle read request and its address
//   imem_rvalid, imem_rdata  : read response
//   pc_id, pc4_id            : PC and PC+4 of the instruction in IF/ID
//   instruction_id, valid_id : instruction to ID and its valid flag
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcwrite,
  input  logic            ifidwrite,
  input  logic            redirect,
  input  logic [XLEN-1:0] target_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc4_id,
  output logic [XLEN-1:0] instruction_id,
  output logic            valid_id
);

  if_state_e       state_d, state_q;
  logic [XLEN-1:0] fetch_pc_d, fetch_pc_q;
  logic [XLEN-1:0] skid_d, skid_q;

  logic            commit;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] fetch_pc_plus4;
  logic            ifid_load;
  logic [XLEN-1:0] ifid_inst;
  logic            unused_target_lsbs;

  // A mismatched pcwrite/ifidwrite pair is treated as a stall.
  assign commit             = pcwrite & ifidwrite;
  assign target_aligned     = {target_pc[XLEN-1:2], 2'b00};
  assign fetch_pc_plus4     = fetch_pc_q + XLEN'(4);
  assign unused_target_lsbs = ^target_pc[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    skid_d     = skid_q;
    imem_req   = 1'b0;
    ifid_load  = 1'b0;
    ifid_inst  = imem_rdata;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          fetch_pc_d = target_aligned;
        end else begin
          imem_req = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          fetch_pc_d = target_aligned;
          // Same-cycle response is simply discarded; otherwise wait it out.
          state_d    = imem_rvalid ? StIdle : StDrop;
        end else if (imem_rvalid) begin
          if (commit) begin
            ifid_load  = 1'b1;
            fetch_pc_d = fetch_pc_plus4;
            state_d    = StIdle;
          end else begin
            skid_d  = imem_rdata;
            state_d = StFull;
          end
        end
      end
      StDrop: begin
        if (redirect) fetch_pc_d = target_aligned;
        if (imem_rvalid) state_d = StIdle;
      end
      StFull: begin
        if (redirect) begin
          skid_d     = '0;
          fetch_pc_d = target_aligned;
          state_d    = StIdle;
        end else if (commit) begin
          ifid_load  = 1'b1;
          ifid_inst  = skid_q;
          fetch_pc_d = fetch_pc_plus4;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      skid_q     <= skid_d;
    end
  end

  assign imem_addr = fetch_pc_q;

  if_id_reg u_if_id_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect),
    .write_i (ifidwrite),
    .load_i  (ifid_load),
    .pc_i    (fetch_pc_q),
    .inst_i  (ifid_inst),
    .pc_o    (pc_id),
    .pc4_o   (pc4_id),
    .inst_o  (instruction_id),
    .valid_o (valid_id)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by randomized stall / redirect /
// latency / reset traffic. A memory model answers requests with addr+0x100, and a
// transaction-level reference (outstanding/live/buffered flags plus the next fetch
// address) predicts the request stream and the IF/ID contents every cycle.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcwrite = 1'b1;
  logic        ifidwrite = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] target_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_id, pc4_id, instruction_id;
  logic        valid_id;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcwrite        (pcwrite),
    .ifidwrite      (ifidwrite),
    .redirect       (redirect),
    .target_pc      (target_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_id          (pc_id),
    .pc4_id         (pc4_id),
    .instruction_id (instruction_id),
    .valid_id       (valid_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle drive values
  bit          d_rst = 1'b1, d_stall = 1'b0, d_redir = 1'b0;
  logic [31:0] d_tgt = '0;
  int          d_lat = 1;

  // Memory model
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_due = 0;
  int          cyc = 0;

  // Reference model
  bit          m_known = 1'b0, m_busy = 1'b0, m_live = 1'b0, m_buf_ok = 1'b0;
  logic [31:0] m_pc = '0, m_buf = '0;
  logic [31:0] e_pc = '0, e_pc4 = 32'd4, e_inst = 32'h13;
  bit          e_valid = 1'b0;

  // Last sampled DUT outputs
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_pc4, obs_inst;

  task automatic cycle();
    bit          rv, idle, exp_req, got, deliver;
    logic [31:0] rd, dinst;
    @(negedge clk);
    rst       = d_rst;
    pcwrite   = !d_stall;
    ifidwrite = !d_stall;
    redirect  = d_redir;
    target_pc = d_tgt;
    rv = mem_busy && (cyc == mem_due);
    rd = rv ? (mem_addr + 32'h100) : $urandom;
    imem_rvalid = rv;
    imem_rdata  = rd;
    #1;
    obs_req = imem_req;   obs_addr = imem_addr; obs_valid = valid_id;
    obs_pc  = pc_id;      obs_pc4  = pc4_id;    obs_inst  = instruction_id;

    idle    = !m_busy && !m_buf_ok;
    exp_req = idle && !d_redir;
    if (m_known) begin
      check_eq("imem_req", obs_req, exp_req);
      if (exp_req) check_eq("imem_addr", obs_addr, m_pc);
      check_eq("valid_id", obs_valid, e_valid);
      check_eq("instruction_id", obs_inst, e_inst);
      check_eq("pc_id", obs_pc, e_pc);
      check_eq("pc4_id", obs_pc4, e_pc4);
    end

    if (d_rst) begin
      m_known = 1'b1; m_busy = 1'b0; m_live = 1'b0; m_buf_ok = 1'b0; m_pc = RST_PC;
      e_pc = '0; e_pc4 = 32'd4; e_inst = 32'h13; e_valid = 1'b0;
    end else if (m_known) begin
      got = m_busy && rv;
      deliver = 1'b0;
      dinst = '0;
      if (d_redir) begin
        m_pc = {d_tgt[31:2], 2'b00};
        m_buf_ok = 1'b0;
        if (got) m_busy = 1'b0;
        else if (m_busy) m_live = 1'b0;
        e_valid = 1'b0; e_inst = 32'h13;
      end else begin
        if (idle) begin
          m_busy = 1'b1; m_live = 1'b1;
        end else if (got) begin
          m_busy = 1'b0;
          if (m_live) begin
            if (!d_stall) begin deliver = 1'b1; dinst = rd; end
            else begin m_buf_ok = 1'b1; m_buf = rd; end
          end
        end else if (m_buf_ok && !d_stall) begin
          deliver = 1'b1; dinst = m_buf; m_buf_ok = 1'b0;
        end
        if (!d_stall) begin
          if (deliver) begin
            e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_inst = dinst; e_valid = 1'b1;
            m_pc = m_pc + 32'd4;
          end else begin
            e_valid = 1'b0; e_inst = 32'h13;
          end
        end
      end
    end

    // Memory shares the reset for new requests but not for one already in flight.
    if (rv) mem_busy = 1'b0;
    if (obs_req === 1'b1 && !d_rst) begin
      check_eq("single_outstanding", {31'b0, mem_busy}, 32'd0);
      mem_busy = 1'b1; mem_addr = obs_addr; mem_due = cyc + d_lat;
    end
    cyc++;
  endtask

  task automatic run_until_req(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      cycle();
      seen = (obs_req === 1'b1);
    end
    check_eq("req_within_budget", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    // Reset, latency-1 stream
    d_rst = 1'b1; d_lat = 1;
    repeat (2) cycle();
    d_rst = 1'b0;
    cycle();                                   // request @0
    check_eq("first_req_addr", obs_addr, RST_PC);
    cycle();                                   // response, load
    cycle();
    check_eq("s1_pc0", obs_pc, 32'h0);
    check_eq("s1_inst0", obs_inst, 32'h100);
    check_eq("s1_valid_hi", {31'b0, obs_valid}, 32'd1);
    cycle();
    check_eq("s1_valid_lo", {31'b0, obs_valid}, 32'd0);
    cycle();
    check_eq("s1_pc4", obs_pc, 32'h4);
    check_eq("s1_inst4", obs_inst, 32'h104);
    check_eq("s1_addr8", obs_addr, 32'h8);

    // Stall while response for pc=8 arrives
    d_stall = 1'b1;
    repeat (3) cycle();
    check_eq("s2_hold_valid", {31'b0, obs_valid}, 32'd0);
    d_stall = 1'b0;
    cycle();                                   // commit from buffer
    d_lat = 4; d_stall = 1'b1;                 // hold IF/ID valid into WAIT
    cycle();
    check_eq("s2_pc8", obs_pc, 32'h8);
    check_eq("s2_inst8", obs_inst, 32'h108);
    check_eq("s2_next_addr", obs_addr, 32'hC);

    // Redirect in WAIT (latency 4) with ifidwrite=0: flush anyway, drop stale
    d_redir = 1'b1; d_tgt = 32'h40;
    cycle();
    d_redir = 1'b0;
    cycle();
    check_eq("s3_flush_valid", {31'b0, obs_valid}, 32'd0);
    d_stall = 1'b0; d_lat = 2;
    run_until_req(10);
    check_eq("s3_redirect_addr", obs_addr, 32'h40);

    // Redirect with same-cycle response, unaligned target
    cycle();
    d_redir = 1'b1; d_tgt = 32'h43;
    cycle();
    d_redir = 1'b0;
    cycle();
    check_eq("s4_req_no_drop", {31'b0, obs_req}, 32'd1);
    check_eq("s4_addr_aligned", obs_addr, 32'h40);

    // Wrap at top of address space
    d_lat = 1; d_redir = 1'b1; d_tgt = 32'hFFFF_FFFC;
    cycle();
    d_redir = 1'b0;
    run_until_req(10);
    check_eq("s5_top_addr", obs_addr, 32'hFFFF_FFFC);
    cycle();
    d_lat = 2;
    run_until_req(4);
    check_eq("s5_wrap_addr", obs_addr, 32'h0);
    check_eq("s5_wrap_pc4", obs_pc4, 32'h0);
    check_eq("s5_top_pc", obs_pc, 32'hFFFF_FFFC);

    // Reset while in WAIT; stale response arrives in IDLE
    d_rst = 1'b1;
    cycle();
    d_rst = 1'b0;
    cycle();
    check_eq("s6_req_after_rst", {31'b0, obs_req}, 32'd1);
    check_eq("s6_addr_after_rst", obs_addr, RST_PC);
    check_eq("s6_valid_after_rst", {31'b0, obs_valid}, 32'd0);
    cycle();
    check_eq("s6_stale_ignored", {31'b0, obs_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_stall = ($urandom_range(0, 99) < 30);
      d_redir = ($urandom_range(0, 99) < 10);
      d_tgt   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
      d_lat   = $urandom_range(1, 4);
      d_rst   = !mem_busy && ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
